uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer between the UART byte interface and the on-chip register bus.
//  Parses 3-byte frames {FLOW, ADDR, DATA} arriving on RX:
//   - FLOW[0]=0: writes DATA to ADDR.
//   - FLOW[0]=1: reads ADDR and returns one byte on TX; DATA is a don't-care pad byte.
//  Sits between UART (RX_DONE/DATA_OUT, TRG_WRITE/DATA_IN) and the scoreboard register file.
// PARAMETERS
//  TIMEOUT_CYC  500000  max idle cycles between bytes of one frame (10 ms @ 50 MHz)
//  RD_LAT       1       cycles from REG_RE to valid REG_RDATA (1..7)
// PORTS
//  CLK_50MHZ  in   1  main clock; the only clock
//  RST        in   1  reset, synchronous, active-high
//  RX_DONE    in   1  one-cycle pulse: RX_DATA holds a new received byte
//  RX_DATA    in   8  received byte
//  TX_BUSY    in   1  UART transmitter busy; rises the cycle after TX_TRG, falls when byte sent
//  TX_TRG     out  1  one-cycle pulse: start transmitting TX_DATA
//  TX_DATA    out  8  byte to transmit; held stable from TX_TRG until TX_BUSY falls
//  REG_ADDR   out  8  register address
//  REG_WDATA  out  8  register write data
//  REG_WE     out  1  one-cycle write strobe
//  REG_RE     out  1  one-cycle read strobe
//  REG_RDATA  in   8  read data, valid RD_LAT cycles after REG_RE
//  BUSY       out  1  high whenever state != IDLE
//  FRAME_ERR  out  1  one-cycle pulse on inter-byte timeout
//  OVERRUN    out  1  one-cycle pulse when an RX byte is dropped (see below)
//  CMD_CNT    out  8  count of completed commands (write or read); wraps 255->0
// BEHAVIOUR
//  Reset: all outputs 0. State=IDLE. Timeout/latency counters cleared.
//   RST during any state aborts the frame: no strobe, no TX. A TX already started in the UART is not recalled.
//  States and transitions:
//   IDLE:      RX_DONE -> latch FLOW[0] into is_rd -> WAIT_ADDR.
//   WAIT_ADDR: RX_DONE -> REG_ADDR<=RX_DATA -> WAIT_DATA.
//   WAIT_DATA: RX_DONE -> REG_WDATA<=RX_DATA.
//              If is_rd=0 -> WRITE; else -> READ.
//   WRITE:     REG_WE=1 for exactly one cycle; CMD_CNT++ -> IDLE.
//   READ:      REG_RE=1 for one cycle; then wait RD_LAT cycles.
//              Capture REG_RDATA into TX_DATA -> SEND.
//   SEND:      when TX_BUSY=0: TX_TRG=1 for one cycle -> SEND_WAIT.
//   SEND_WAIT: wait TX_BUSY rise, then fall; CMD_CNT++ -> IDLE.
//  Latency:
//   REG_WE asserts the cycle after the 3rd RX_DONE.
//   REG_RE asserts the cycle after the 3rd RX_DONE.
//   TX_TRG asserts RD_LAT+1 cycles after REG_RE, if TX_BUSY is low.
//  Timeout: counter clears on every accepted RX_DONE; runs only in WAIT_ADDR/WAIT_DATA.
//   Reaching TIMEOUT_CYC-1: FRAME_ERR pulse, -> IDLE, no strobe.
//  FLOW bits[7:1]: ignored.
//  Dropped bytes: RX_DONE in WRITE/READ/SEND/SEND_WAIT -> byte discarded, OVERRUN pulse,
//   state unaffected. The next frame starts at the first byte received in IDLE.
//  RX_DONE in the same cycle as timeout expiry: the byte is accepted and the timeout is suppressed.
//  CMD_CNT: 8-bit, modulo 256.
// STRUCTURE
//  Shared package (rs232 protocol constants): FLOW_WR=8'h00, FLOW_RD=8'h01, FRAME_LEN=3.
//   The state encoding lives in the same package so the bench FSM monitor can decode it.
//  One sub-module: uart_cmd_timeout (loadable down-counter, clear/enable, expire pulse).
// TESTING
//  1 Write: RX 00,7B,02 -> REG_WE one cycle, REG_ADDR=7B, REG_WDATA=02; CMD_CNT=1; no TX_TRG.
//  2 Read: RX 01,7B,FF, REG_RDATA=02 -> REG_RE once, TX_TRG once with TX_DATA=02.
//   CMD_CNT increments only after TX_BUSY falls.
//  3 Timeout: RX 00,EA then silence TIMEOUT_CYC cycles (bench TIMEOUT_CYC=100)
//   -> FRAME_ERR pulse, no REG_WE. Next RX 00,EA,05 -> write EA<=05.
//  4 Overrun: during SEND_WAIT of a read, inject RX_DONE with 0x00 -> OVERRUN pulse.
//   TX completes normally; next full frame is decoded correctly.
//  5 Reset mid-frame: RX 00,7B, then RST for 1 cycle -> outputs 0, IDLE.
//   RX 01,7B,FF -> read of 7B (not a write).
//  6 Wrap: 256 back-to-back writes (RD_LAT=3 variant also run for reads)
//   -> CMD_CNT returns to 00; every REG_WE exactly one cycle.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared rs232 command-frame constants and the sequencer state encoding,
// kept here so monitors outside the RTL can decode the FSM state.
package uart_cmd_ctrl_pkg;

  localparam logic [7:0] FLOW_WR   = 8'h00;
  localparam logic [7:0] FLOW_RD   = 8'h01;
  localparam int         FRAME_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_WRITE     = 3'd3,
    ST_READ      = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_SEND      = 3'd6,
    ST_SEND_WAIT = 3'd7
  } state_t;

  // Only bit 0 of the flow byte selects the command; the rest is ignored.
  function automatic logic flow_is_read(input logic flow_bit0);
    return flow_bit0 == FLOW_RD[0];
  endfunction

  // States in which the sequencer is executing a command and cannot take RX bytes.
  function automatic logic drops_rx(input state_t s);
    return s inside {ST_WRITE, ST_READ, ST_RD_WAIT, ST_SEND, ST_SEND_WAIT};
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte timeout: loadable down-counter that pulses expire once it has
// run TIMEOUT_CYC enabled cycles without a clear.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= LOAD;
    end else if (clr) begin
      cnt_reg <= LOAD;
    end else if (en && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  // A clear in the expiry cycle wins, so a late byte is still accepted.
  assign expire = en && !clr && (cnt_reg == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: decodes {FLOW, ADDR, DATA} UART frames into register-bus
// writes, or reads that return one byte over the UART transmitter.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 500000,
  parameter int RD_LAT      = 1
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX_DONE,
  input  logic [7:0] RX_DATA,
  input  logic       TX_BUSY,
  output logic       TX_TRG,
  output logic [7:0] TX_DATA,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  output logic       REG_RE,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic [7:0] CMD_CNT
);

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_t     state_reg, state_next;
  logic       is_rd_reg, is_rd_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic [2:0] lat_reg, lat_next;
  logic       tx_seen_reg, tx_seen_next;
  logic [7:0] cmd_cnt_reg, cmd_cnt_next;
  logic       frame_err_reg, frame_err_next;
  logic       overrun_reg, overrun_next;

  logic to_en;
  logic to_clr;
  logic to_expire;

  // The timeout only runs while a frame is partially received.
  assign to_en  = (state_reg == ST_WAIT_ADDR) || (state_reg == ST_WAIT_DATA);
  assign to_clr = RX_DONE || !to_en;

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk   (CLK_50MHZ),
    .srst  (RST),
    .clr   (to_clr),
    .en    (to_en),
    .expire(to_expire)
  );

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      is_rd_reg     <= 1'b0;
      addr_reg      <= 8'h00;
      wdata_reg     <= 8'h00;
      tx_data_reg   <= 8'h00;
      lat_reg       <= 3'd0;
      tx_seen_reg   <= 1'b0;
      cmd_cnt_reg   <= 8'h00;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      is_rd_reg     <= is_rd_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      tx_data_reg   <= tx_data_next;
      lat_reg       <= lat_next;
      tx_seen_reg   <= tx_seen_next;
      cmd_cnt_reg   <= cmd_cnt_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    is_rd_next     = is_rd_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    tx_data_next   = tx_data_reg;
    lat_next       = lat_reg;
    tx_seen_next   = tx_seen_reg;
    cmd_cnt_next   = cmd_cnt_reg;
    frame_err_next = 1'b0;
    overrun_next   = RX_DONE && drops_rx(state_reg);
    TX_TRG         = 1'b0;
    REG_WE         = 1'b0;
    REG_RE         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (RX_DONE) begin
          is_rd_next = flow_is_read(RX_DATA[0]);
          state_next = ST_WAIT_ADDR;
        end
      end
      ST_WAIT_ADDR: begin
        if (RX_DONE) begin
          addr_next  = RX_DATA;
          state_next = ST_WAIT_DATA;
        end else if (to_expire) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        if (RX_DONE) begin
          wdata_next = RX_DATA;
          state_next = is_rd_reg ? ST_READ : ST_WRITE;
        end else if (to_expire) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_WRITE: begin
        REG_WE       = 1'b1;
        cmd_cnt_next = cmd_cnt_reg + 8'd1;
        state_next   = ST_IDLE;
      end
      ST_READ: begin
        REG_RE     = 1'b1;
        lat_next   = LAT_LOAD;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Last wait cycle is the one in which REG_RDATA is valid.
        if (lat_reg == 3'd0) begin
          tx_data_next = REG_RDATA;
          state_next   = ST_SEND;
        end else begin
          lat_next = lat_reg - 3'd1;
        end
      end
      ST_SEND: begin
        if (!TX_BUSY) begin
          TX_TRG       = 1'b1;
          tx_seen_next = 1'b0;
          state_next   = ST_SEND_WAIT;
        end
      end
      ST_SEND_WAIT: begin
        if (TX_BUSY) begin
          tx_seen_next = 1'b1;
        end else if (tx_seen_reg) begin
          cmd_cnt_next = cmd_cnt_reg + 8'd1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign TX_DATA   = tx_data_reg;
  assign REG_ADDR  = addr_reg;
  assign REG_WDATA = wdata_reg;
  assign BUSY      = (state_reg != ST_IDLE);
  assign FRAME_ERR = frame_err_reg;
  assign OVERRUN   = overrun_reg;
  assign CMD_CNT   = cmd_cnt_reg;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: two instances (RD_LAT=1 and RD_LAT=3) share RX stimulus;
// expected bus/TX events are queued at stimulus time and popped by per-instance monitors.
module tb_uart_cmd_ctrl;
  import uart_cmd_ctrl_pkg::*;

  localparam int TO = 100;
  localparam int TX_LEN = 12;
  localparam logic [7:0] POISON = 8'h5A;

  typedef enum logic [2:0] {EV_WR, EV_RD, EV_TX, EV_FE, EV_OV} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int checks = 0;
  int failures = 0;
  ev_t exp_q0[$];
  ev_t exp_q1[$];
  logic [7:0] model_mem [256];
  logic [7:0] exp_cnt = 8'h00;

  function automatic ev_t mk_ev(ev_kind_t k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.a = a;
    e.d = d;
    return e;
  endfunction

  task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(ev_t e);
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  task automatic check_ev(int idx, ev_t got);
    ev_t exp;
    int depth;
    depth = (idx == 0) ? exp_q0.size() : exp_q1.size();
    checks++;
    assert (depth > 0) else begin
      failures++;
      $error("FAIL event_unexpected dut%0d observed=%0d/%02h/%02h expected=none",
             idx, got.kind, got.a, got.d);
    end
    if (depth == 0) return;
    exp = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    assert (got === exp) else begin
      failures++;
      $error("FAIL event dut%0d observed=%0d/%02h/%02h expected=%0d/%02h/%02h",
             idx, got.kind, got.a, got.d, exp.kind, exp.a, exp.d);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : 3;

    logic       tx_busy = 1'b0;
    int         busy_cnt = 0;
    logic       tx_trg, reg_we, reg_re, busy, frame_err, overrun;
    logic [7:0] tx_data, reg_addr, reg_wdata, reg_rdata, cmd_cnt;
    logic [7:0] mem [256];
    logic [7:0] pd [LAT];
    logic       pv [LAT];
    int         cyc = 0;
    int         re_cyc = 0;

    uart_cmd_ctrl #(.TIMEOUT_CYC(TO), .RD_LAT(LAT)) dut (
      .CLK_50MHZ(clk), .RST(rst), .RX_DONE(rx_done), .RX_DATA(rx_data),
      .TX_BUSY(tx_busy), .TX_TRG(tx_trg), .TX_DATA(tx_data),
      .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we), .REG_RE(reg_re),
      .REG_RDATA(reg_rdata), .BUSY(busy), .FRAME_ERR(frame_err), .OVERRUN(overrun),
      .CMD_CNT(cmd_cnt)
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int k = 0; k < LAT; k++) begin
        pd[k] = 8'h00;
        pv[k] = 1'b0;
      end
    end

    // Register file: read data valid exactly LAT cycles after REG_RE, poison otherwise.
    always @(posedge clk) begin
      pd[0] <= mem[reg_addr];
      pv[0] <= reg_re;
      for (int k = 1; k < LAT; k++) begin
        pd[k] <= pd[k-1];
        pv[k] <= pv[k-1];
      end
      if (reg_we) mem[reg_addr] <= reg_wdata;
    end
    assign reg_rdata = pv[LAT-1] ? pd[LAT-1] : POISON;

    // UART transmitter: busy from the cycle after TX_TRG for TX_LEN cycles.
    always @(posedge clk) begin
      if (tx_trg) begin
        tx_busy  <= 1'b1;
        busy_cnt <= TX_LEN;
      end else if (busy_cnt > 1) begin
        busy_cnt <= busy_cnt - 1;
      end else if (busy_cnt == 1) begin
        busy_cnt <= 0;
        tx_busy  <= 1'b0;
      end
    end

    always @(negedge clk) begin
      cyc++;
      if (!rst) begin
        if (reg_we) check_ev(gi, mk_ev(EV_WR, reg_addr, reg_wdata));
        if (reg_re) begin
          check_ev(gi, mk_ev(EV_RD, reg_addr, 8'h00));
          re_cyc = cyc;
        end
        if (tx_trg) begin
          check_ev(gi, mk_ev(EV_TX, 8'h00, tx_data));
          check8("tx_latency", 8'(cyc - re_cyc), 8'(LAT + 1));
        end
        if (frame_err) check_ev(gi, mk_ev(EV_FE, 8'h00, 8'h00));
        if (overrun) check_ev(gi, mk_ev(EV_OV, 8'h00, 8'h00));
      end
    end
  end

  task automatic tick(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(logic [7:0] b, int idle);
    tick(idle);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(logic [7:0] f, logic [7:0] a, logic [7:0] d, int idle, int inner);
    logic [7:0] fb [FRAME_LEN];
    fb = '{f, a, d};
    if (f[0]) begin
      push_exp(mk_ev(EV_RD, a, 8'h00));
      push_exp(mk_ev(EV_TX, 8'h00, model_mem[a]));
    end else begin
      push_exp(mk_ev(EV_WR, a, d));
      model_mem[a] = d;
    end
    exp_cnt = exp_cnt + 8'd1;
    for (int i = 0; i < FRAME_LEN; i++) send_byte(fb[i], (i == 0) ? idle : inner);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while ((g_dut[0].busy || g_dut[1].busy || g_dut[0].tx_busy || g_dut[1].tx_busy) && n < 1000) begin
      tick(1);
      n++;
    end
    checks++;
    assert (n < 1000) else begin
      failures++;
      $error("FAIL %s_idle_wait observed=busy expected=idle", tag);
    end
  endtask

  task automatic check_cnt(string tag);
    check8({tag, "_cnt0"}, g_dut[0].cmd_cnt, exp_cnt);
    check8({tag, "_cnt1"}, g_dut[1].cmd_cnt, exp_cnt);
  endtask

  function automatic logic [7:0] flags(int idx);
    if (idx == 0)
      return {2'b00, g_dut[0].tx_trg, g_dut[0].reg_we, g_dut[0].reg_re,
              g_dut[0].busy, g_dut[0].frame_err, g_dut[0].overrun};
    return {2'b00, g_dut[1].tx_trg, g_dut[1].reg_we, g_dut[1].reg_re,
            g_dut[1].busy, g_dut[1].frame_err, g_dut[1].overrun};
  endfunction

  initial begin
    int n;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // Reset state
    tick(3);
    check8("rst_flags0", flags(0), 8'h00);
    check8("rst_flags1", flags(1), 8'h00);
    check8("rst_tx_data", g_dut[0].tx_data, 8'h00);
    check8("rst_reg_addr", g_dut[0].reg_addr, 8'h00);
    check8("rst_reg_wdata", g_dut[0].reg_wdata, 8'h00);
    check_cnt("rst");
    rst = 1'b0;
    tick(2);

    // Write 7B <= 02
    send_frame(FLOW_WR, 8'h7B, 8'h02, 1, 0);
    wait_idle("wr");
    check_cnt("wr");
    check8("wr_addr", g_dut[0].reg_addr, 8'h7B);
    check8("wr_wdata", g_dut[0].reg_wdata, 8'h02);

    // Read 7B: count must not move until the transmitter finishes
    send_frame(FLOW_RD, 8'h7B, 8'hFF, 1, 0);
    n = 0;
    while (!g_dut[1].tx_busy && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    assert (n < 200) else begin
      failures++;
      $error("FAIL rd_tx_wait observed=no_tx expected=tx_busy");
    end
    check8("rd_cnt_pending0", g_dut[0].cmd_cnt, exp_cnt - 8'd1);
    check8("rd_cnt_pending1", g_dut[1].cmd_cnt, exp_cnt - 8'd1);
    wait_idle("rd");
    check_cnt("rd");

    // Timeout after two bytes, then a clean frame
    push_exp(mk_ev(EV_FE, 8'h00, 8'h00));
    send_byte(FLOW_WR, 1);
    send_byte(8'hEA, 0);
    wait_idle("to");
    check_cnt("to");
    send_frame(FLOW_WR, 8'hEA, 8'h05, 1, 0);
    wait_idle("to_wr");
    check_cnt("to_wr");

    // Bytes landing exactly in the expiry cycle are still accepted
    send_frame(FLOW_WR, 8'h3C, 8'h11, 1, TO - 1);
    wait_idle("to_edge");
    check_cnt("to_edge");
    check8("to_edge_wdata", g_dut[0].reg_wdata, 8'h11);

    // Overrun while a read is transmitting
    send_frame(FLOW_RD, 8'h7B, 8'hFF, 1, 0);
    n = 0;
    while (!g_dut[0].tx_trg && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      failures++;
      $error("FAIL ovr_trg_wait observed=no_trg expected=tx_trg");
    end
    tick(4);
    push_exp(mk_ev(EV_OV, 8'h00, 8'h00));
    send_byte(8'h00, 0);
    wait_idle("ovr");
    check_cnt("ovr");
    send_frame(FLOW_WR, 8'h44, 8'h99, 1, 0);
    send_frame(FLOW_RD, 8'h44, 8'h00, 1, 0);
    wait_idle("ovr_after");
    check_cnt("ovr_after");

    // Reset mid-frame
    send_byte(FLOW_WR, 1);
    send_byte(8'h7B, 0);
    rst = 1'b1;
    tick(1);
    exp_cnt = 8'h00;
    check8("mid_rst_flags0", flags(0), 8'h00);
    check8("mid_rst_flags1", flags(1), 8'h00);
    check_cnt("mid_rst");
    rst = 1'b0;
    tick(1);
    send_frame(FLOW_RD, 8'h7B, 8'hFF, 1, 0);
    wait_idle("rst_rd");
    check_cnt("rst_rd");

    // Counter wrap: 255 writes reach FF, the 256th wraps to 00
    exp_cnt = 8'h00;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 255; i++) send_frame(FLOW_WR, 8'(i), ~8'(i), 1, 0);
    wait_idle("wrap255");
    check8("wrap_ff", g_dut[0].cmd_cnt, 8'hFF);
    send_frame(FLOW_WR, 8'hFF, 8'h00, 1, 0);
    wait_idle("wrap256");
    check8("wrap_00_dut0", g_dut[0].cmd_cnt, 8'h00);
    check8("wrap_00_dut1", g_dut[1].cmd_cnt, 8'h00);

    // Reads back over both latency variants
    send_frame(FLOW_RD, 8'h7B, 8'h00, 1, 0);
    wait_idle("rb");
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      send_frame(FLOW_RD, a, 8'($urandom_range(0, 255)), 1, 0);
      wait_idle("rb_rand");
    end
    check_cnt("rb");

    tick(5);
    check8("q0_empty", 8'(exp_q0.size()), 8'h00);
    check8("q1_empty", 8'(exp_q1.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
